pdm_mic_array: RTL and testbench
================================

Name: pdm_mic_array

Overview:
- Multi-line, multi-channel PDM microphone receiver for the LiteX SoC. Runs entirely in the system clock domain: no derived clock and no CDC.
- Generates the PDM bit clock as a clock-enable. Samples each data line on both clock phases, giving two mics (L/R) per line.
- Runs a 3rd-order CIC decimator per channel, with the comb shared and time-multiplexed.
- Pushes interleaved PCM frames into an output FIFO with a valid/ready stream interface.

Parameters:
- NUM_LINES, 1: PDM data pins. NCH = 2*NUM_LINES channels.
- DECIMATION, 64: CIC rate R. Power of two, 4..256.
- OUT_WIDTH, 16: PCM sample width.
- FIFO_DEPTH, 16: output FIFO entries. Power of two, at least 2*NCH.

Derived:
- CIC_W = 3*log2(DECIMATION)+2.
- CH_W = max(1, clog2(NCH)).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  run; low stops the clock and clears the filters.
- period  in  16  PDM clock period in clk cycles.
- pdm_data_in  in  NUM_LINES  PDM data, asynchronous.
- pdm_clk_out  out  1  PDM clock to the mics.
- m_data  out  OUT_WIDTH  signed PCM sample.
- m_channel  out  CH_W  channel index of m_data.
- m_last  out  1  high on the last channel (NCH-1) of a frame.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- fifo_level  out  clog2(FIFO_DEPTH+1)  occupied entries.
- overflow  out  1  sticky, set when a frame is dropped.
- clear_overflow  in  1  clears overflow.

Behaviour:
- Reset values: pdm_clk_out=0, m_valid=0, m_data=0, m_channel=0, m_last=0, fifo_level=0, overflow=0. All counters, integrators, combs and the FIFO are cleared. Reset mid-frame discards everything in flight.
- Clock generation:
  - half = max(1, period>>1).
  - The counter runs 0..half-1; at half-1 it wraps and pdm_clk toggles.
  - A "rise event" is the cycle pdm_clk goes 0->1; a "fall event" is the cycle it goes 1->0.
  - period is read live; a change takes effect at the next wrap.
  - enable=0: counter=0, pdm_clk=0, integrators/combs/decimation counter/settle counter cleared. The FIFO and overflow are retained so software can drain.
- Input: each line passes through a 2-flop synchroniser.
- Channel mapping:
  - Channel 2k takes line k's synchronised value at a rise event (left mic).
  - Channel 2k+1 takes line k's synchronised value at a fall event (right mic).
  - Bit 1 maps to +1, bit 0 maps to -1.
- Integrators: 3 per channel, CIC_W bits, two's-complement wrap. Each integrates once per corresponding event.
- Decimation:
  - A counter counts rise events, 0..DECIMATION-1.
  - At the rise event where it wraps (the decimation event), the post-update integrator-3 values of all channels are latched into a snapshot bank.
- Comb sequencer (FSM IDLE -> COMB -> IDLE):
  - Starting the cycle after a decimation event, it processes one channel per cycle in order 0..NCH-1 through 3 comb stages (differential delay 1, per-channel delay registers).
  - Result = comb output >>> (CIC_W-OUT_WIDTH), or left-shifted by (OUT_WIDTH-CIC_W) if negative.
  - Full-scale +1 input gives +2^(OUT_WIDTH-2) for CIC_W>=OUT_WIDTH.
- Settle: the first 3 frames after enable rises or after reset are computed but not pushed.
- FIFO push and overflow:
  - Frames are pushed atomically. At the decimation event, if free entries < NCH, the whole frame is dropped: combs still update, overflow is set, and nothing is written.
  - A frame is never split.
  - Channel c is written at decimation event + 1 + c, as the entry {m_last, m_channel, m_data}.
- FIFO read:
  - First-word-fall-through. m_valid rises the cycle after the write.
  - Pop occurs when m_valid & m_ready.
  - m_data, m_channel and m_last are stable while m_valid=1 and m_ready=0.
  - Simultaneous push and pop keeps fifo_level unchanged.
- Overflow: if clear_overflow and a new drop occur in the same cycle, overflow stays 1.

Optional Feature:
- PDM_MIC_ARRAY_DROP_CNT_EN defined: adds an output drop_count [15:0]. It increments once per dropped frame, saturates at 0xFFFF, and clears on rst or clear_overflow.
- Undefined: the port and counter are absent; overflow behaviour is unchanged.

Test Plan:
- Clock: enable=1, period=8 -> pdm_clk_out is high 4 and low 4 cycles. Set enable=0 mid-high -> pdm_clk_out=0 the next cycle.
- Full scale, NUM_LINES=1, DECIMATION=64, OUT_WIDTH=16, line held 1 -> after 3 discarded frames, ch0 and ch1 both read 16384 with m_last=1 on ch1. Line held 0 -> both read -16384.
- Phase separation: period=8, line = pdm_clk_out (high in high phase) -> ch0 settles to -16384 and ch1 to +16384.
- Ordering, NUM_LINES=2 -> every frame is m_channel 0,1,2,3 with m_last only on 3. ch2 is written 3 cycles after the decimation event.
- Overflow: m_ready=0, FIFO_DEPTH=16, NCH=2 -> 8 frames are stored, the 9th is dropped, overflow=1 and fifo_level=16. Release m_ready -> the 16 entries drain in order with no split frame. clear_overflow -> overflow=0.
- Reset with 5 entries queued and mid-comb -> the next cycle shows m_valid=0 and fifo_level=0. The settle is repeated (3 frames discarded).

Source files
------------

// File: rtl/pdm_mic_array.sv
// pdm_mic_array: multi-line PDM microphone receiver with a 3rd-order CIC decimator
// per channel, a time-multiplexed comb and a first-word-fall-through PCM FIFO.
// Optional build macro PDM_MIC_ARRAY_DROP_CNT_EN adds a saturating drop_count output.
module pdm_mic_array #(
    parameter int unsigned NUM_LINES  = 1,
    parameter int unsigned DECIMATION = 64,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    localparam int unsigned NCH   = 2 * NUM_LINES,
    localparam int unsigned CH_W  = (NCH > 2) ? $clog2(NCH) : 1,
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [15:0]          period,
    input  logic [NUM_LINES-1:0] pdm_data_in,
    output logic                 pdm_clk_out,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic [CH_W-1:0]      m_channel,
    output logic                 m_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [LVL_W-1:0]     fifo_level,
    output logic                 overflow,
`ifdef PDM_MIC_ARRAY_DROP_CNT_EN
    output logic [15:0]          drop_count,
`endif
    input  logic                 clear_overflow
);

    localparam int unsigned LOG_R = $clog2(DECIMATION);
    localparam int unsigned CIC_W = 3 * LOG_R + 2;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned ENT_W = 1 + CH_W + OUT_WIDTH;
    localparam int unsigned EXT_W = (CIC_W > OUT_WIDTH) ? CIC_W : OUT_WIDTH;
    localparam int unsigned SHR   = (CIC_W > OUT_WIDTH) ? CIC_W - OUT_WIDTH : 0;
    localparam int unsigned SHL   = (OUT_WIDTH > CIC_W) ? OUT_WIDTH - CIC_W : 0;

    localparam logic signed [CIC_W-1:0] CIC_ONE     = CIC_W'(1);
    localparam logic signed [CIC_W-1:0] CIC_NEG_ONE = '1;
    localparam logic [LOG_R-1:0]        DEC_LAST    = LOG_R'(DECIMATION - 1);
    localparam logic [LVL_W-1:0]        LVL_ROOM    = LVL_W'(FIFO_DEPTH - NCH);
    localparam logic [CH_W-1:0]         CH_LAST     = CH_W'(NCH - 1);

    typedef enum logic {ST_IDLE, ST_COMB} state_t;

    // Bit clock generator
    logic [15:0] clk_cnt_q, clk_cnt_d, half;
    logic        pdm_clk_q, pdm_clk_d;
    logic        wrap, rise_ev, fall_ev, dec_ev;

    // Input synchroniser, decimation and settle counters
    logic [NUM_LINES-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [LOG_R-1:0]     dec_cnt_q, dec_cnt_d;
    logic [1:0]           settle_q, settle_d;

    // Per-channel integrators, snapshot bank and comb delay lines
    logic signed [CIC_W-1:0] int1_q [NCH];
    logic signed [CIC_W-1:0] int1_d [NCH];
    logic signed [CIC_W-1:0] int2_q [NCH];
    logic signed [CIC_W-1:0] int2_d [NCH];
    logic signed [CIC_W-1:0] int3_q [NCH];
    logic signed [CIC_W-1:0] int3_d [NCH];
    logic signed [CIC_W-1:0] snap_q [NCH];
    logic signed [CIC_W-1:0] snap_d [NCH];
    logic signed [CIC_W-1:0] dly1_q [NCH];
    logic signed [CIC_W-1:0] dly1_d [NCH];
    logic signed [CIC_W-1:0] dly2_q [NCH];
    logic signed [CIC_W-1:0] dly2_d [NCH];
    logic signed [CIC_W-1:0] dly3_q [NCH];
    logic signed [CIC_W-1:0] dly3_d [NCH];

    // Shared comb datapath
    logic signed [CIC_W-1:0] comb_in, comb1, comb2, comb3;
    logic signed [EXT_W-1:0] comb_ext, comb_scaled;
    logic [OUT_WIDTH-1:0]    sample;

    // Sequencer and FIFO
    state_t               state_q, state_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic                 push_q, push_d;
    logic                 settled, room, accept, drop, wr_en, pop;
    logic [ENT_W-1:0]     mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]     mem_d [FIFO_DEPTH];
    logic [ENT_W-1:0]     rd_ent;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic                 m_valid_q, m_valid_d;
    logic                 overflow_q, overflow_d;
`ifdef PDM_MIC_ARRAY_DROP_CNT_EN
    logic [15:0]          drop_cnt_q, drop_cnt_d;
`endif

    // Bit clock: half-period counter, toggle on wrap, period sampled live
    always_comb begin
        half      = (period[15:1] == 15'd0) ? 16'd1 : {1'b0, period[15:1]};
        wrap      = enable && (clk_cnt_q >= half - 16'd1);
        clk_cnt_d = (!enable || wrap) ? 16'd0 : clk_cnt_q + 16'd1;
        pdm_clk_d = enable && (wrap ? !pdm_clk_q : pdm_clk_q);
        rise_ev   = wrap && !pdm_clk_q;
        fall_ev   = wrap && pdm_clk_q;
        dec_ev    = rise_ev && (dec_cnt_q == DEC_LAST);
        sync1_d   = pdm_data_in;
        sync2_d   = sync1_q;
        dec_cnt_d = !enable ? '0 : (rise_ev ? dec_cnt_q + LOG_R'(1) : dec_cnt_q);
    end

    // Integrators: even channels step on rise events, odd channels on fall events
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            int1_d[c] = int1_q[c];
            int2_d[c] = int2_q[c];
            int3_d[c] = int3_q[c];
            if (!enable) begin
                int1_d[c] = '0;
                int2_d[c] = '0;
                int3_d[c] = '0;
            end else if ((c % 2 == 0) ? rise_ev : fall_ev) begin
                int1_d[c] = int1_q[c] + (sync2_q[c / 2] ? CIC_ONE : CIC_NEG_ONE);
                int2_d[c] = int2_q[c] + int1_d[c];
                int3_d[c] = int3_q[c] + int2_d[c];
            end
            snap_d[c] = dec_ev ? int3_d[c] : snap_q[c];
        end
    end

    // Shared comb for the channel currently selected by the sequencer
    always_comb begin
        comb_in     = snap_q[ch_q];
        comb1       = comb_in - dly1_q[ch_q];
        comb2       = comb1 - dly2_q[ch_q];
        comb3       = comb2 - dly3_q[ch_q];
        comb_ext    = EXT_W'(comb3);
        comb_scaled = (comb_ext <<< SHL) >>> SHR;
        sample      = OUT_WIDTH'(comb_scaled);
    end

    // Sequencer, settle, frame admission, FIFO and overflow next-state
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        push_d     = push_q;
        settle_d   = settle_q;
        dly1_d     = dly1_q;
        dly2_d     = dly2_q;
        dly3_d     = dly3_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        settled = (settle_q == 2'd3);
        room    = (level_q <= LVL_ROOM);
        accept  = dec_ev && settled && room;
        drop    = dec_ev && settled && !room;
        wr_en   = (state_q == ST_COMB) && push_q;
        pop     = m_valid_q && m_ready;
        rd_ent  = mem_q[rd_ptr_q];

        if (!enable) begin
            settle_d = 2'd0;
        end else if (dec_ev && !settled) begin
            settle_d = settle_q + 2'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (dec_ev) begin
                    state_d = ST_COMB;
                    ch_d    = '0;
                    push_d  = accept;
                end
                // A frame already in flight completes; delays clear once idle
                if (!enable) begin
                    for (int c = 0; c < NCH; c++) begin
                        dly1_d[c] = '0;
                        dly2_d[c] = '0;
                        dly3_d[c] = '0;
                    end
                end
            end
            ST_COMB: begin
                dly1_d[ch_q] = comb_in;
                dly2_d[ch_q] = comb1;
                dly3_d[ch_q] = comb2;
                if (ch_q == CH_LAST) begin
                    state_d = ST_IDLE;
                    push_d  = 1'b0;
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (wr_en) begin
            mem_d[wr_ptr_q] = {(ch_q == CH_LAST), ch_q, sample};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        m_valid_d = (level_d != '0);

        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

`ifdef PDM_MIC_ARRAY_DROP_CNT_EN
    // Saturating dropped-frame counter, cleared with the overflow flag
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clear_overflow) begin
            drop_cnt_d = drop ? 16'd1 : 16'd0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Drop counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt_q  <= 16'd0;
            pdm_clk_q  <= 1'b0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            dec_cnt_q  <= '0;
            settle_q   <= 2'd0;
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            push_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            m_valid_q  <= 1'b0;
            overflow_q <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                int1_q[c] <= '0;
                int2_q[c] <= '0;
                int3_q[c] <= '0;
                snap_q[c] <= '0;
                dly1_q[c] <= '0;
                dly2_q[c] <= '0;
                dly3_q[c] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            clk_cnt_q  <= clk_cnt_d;
            pdm_clk_q  <= pdm_clk_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            dec_cnt_q  <= dec_cnt_d;
            settle_q   <= settle_d;
            state_q    <= state_d;
            ch_q       <= ch_d;
            push_q     <= push_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            m_valid_q  <= m_valid_d;
            overflow_q <= overflow_d;
            int1_q     <= int1_d;
            int2_q     <= int2_d;
            int3_q     <= int3_d;
            snap_q     <= snap_d;
            dly1_q     <= dly1_d;
            dly2_q     <= dly2_d;
            dly3_q     <= dly3_d;
            mem_q      <= mem_d;
        end
    end

    assign pdm_clk_out = pdm_clk_q;
    assign m_data      = rd_ent[OUT_WIDTH-1:0];
    assign m_channel   = rd_ent[OUT_WIDTH +: CH_W];
    assign m_last      = rd_ent[ENT_W-1];
    assign m_valid     = m_valid_q;
    assign fifo_level  = level_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_pdm_mic_array.sv
// Self-checking bench for pdm_mic_array: a one-line and a two-line instance,
// table-driven full-scale/phase vectors plus clock, overflow, reset and ordering sequences.
module tb_pdm_mic_array;

    localparam int BUDGET = 8000;

    typedef struct {
        logic [1:0]  mode;     // 0: line low, 1: line high, 2: line follows pdm_clk_out
        logic [15:0] per;
        int          exp_even;
        int          exp_odd;
    } vec_t;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  ch;
        logic        last;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // One-line instance
    logic        rst, en1, rdy1, clr1, pdm1, pclk1, last1, valid1, ovf1;
    logic [1:0]  mode1;
    logic [15:0] per1, data1;
    logic [0:0]  ch1;
    logic [4:0]  level1;
    // Two-line instance
    logic        en2, rdy2, clr2, pclk2, last2, valid2, ovf2;
    logic [15:0] per2, data2;
    logic [1:0]  pdm2, ch2;
    logic [4:0]  level2;
`ifdef PDM_MIC_ARRAY_DROP_CNT_EN
    logic [15:0] drop1, drop2;
`endif

    assign pdm1 = (mode1 == 2'd2) ? pclk1 : mode1[0];

    ent_t q1[$];
    ent_t q2[$];
    ent_t e1, e2;
    vec_t vecs[6];

    pdm_mic_array #(.NUM_LINES(1), .DECIMATION(64), .OUT_WIDTH(16), .FIFO_DEPTH(16)) u_dut1 (
        .clk(clk), .rst(rst), .enable(en1), .period(per1), .pdm_data_in(pdm1),
        .pdm_clk_out(pclk1), .m_data(data1), .m_channel(ch1), .m_last(last1),
        .m_valid(valid1), .m_ready(rdy1), .fifo_level(level1), .overflow(ovf1),
`ifdef PDM_MIC_ARRAY_DROP_CNT_EN
        .drop_count(drop1),
`endif
        .clear_overflow(clr1)
    );

    pdm_mic_array #(.NUM_LINES(2), .DECIMATION(64), .OUT_WIDTH(16), .FIFO_DEPTH(16)) u_dut2 (
        .clk(clk), .rst(rst), .enable(en2), .period(per2), .pdm_data_in(pdm2),
        .pdm_clk_out(pclk2), .m_data(data2), .m_channel(ch2), .m_last(last2),
        .m_valid(valid2), .m_ready(rdy2), .fifo_level(level2), .overflow(ovf2),
`ifdef PDM_MIC_ARRAY_DROP_CNT_EN
        .drop_count(drop2),
`endif
        .clear_overflow(clr2)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out, required completion within budget", name);
    endtask

    task automatic push_frame1(input int ev, input int od);
        q1.push_back('{data: 16'(ev), ch: 2'd0, last: 1'b0});
        q1.push_back('{data: 16'(od), ch: 2'd1, last: 1'b1});
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_q1_empty(input string name);
        int t = 0;
        while (q1.size() != 0 && t < BUDGET) begin
            @(negedge clk);
            t++;
        end
        if (q1.size() != 0) begin
            timeout_fail(name);
            q1.delete();
        end
    endtask

    // Scoreboard for the one-line instance
    always begin
        @(negedge clk);
        #1;
        if (!rst && valid1 && rdy1) begin
            if (q1.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pop1: got unexpected entry data %0d ch %0d, required none",
                         $signed(data1), ch1);
            end else begin
                e1 = q1.pop_front();
                check("m_data1", int'($signed(data1)), int'($signed(e1.data)));
                check("m_channel1", int'(ch1), int'(e1.ch));
                check("m_last1", int'(last1), int'(e1.last));
            end
        end
    end

    // Scoreboard for the two-line instance
    always begin
        @(negedge clk);
        #1;
        if (!rst && valid2 && rdy2) begin
            if (q2.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL pop2: got unexpected entry data %0d ch %0d, required none",
                         $signed(data2), ch2);
            end else begin
                e2 = q2.pop_front();
                check("m_data2", int'($signed(data2)), int'($signed(e2.data)));
                check("m_channel2", int'(ch2), int'(e2.ch));
                check("m_last2", int'(last2), int'(e2.last));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required end of test");
        $fatal(1);
    end

    initial begin
        int hi, lo, t, idx, rise_idx;
        logic prev;

        vecs[0] = '{mode: 2'd1, per: 16'd8,  exp_even:  16384, exp_odd:  16384};
        vecs[1] = '{mode: 2'd0, per: 16'd8,  exp_even: -16384, exp_odd: -16384};
        vecs[2] = '{mode: 2'd2, per: 16'd8,  exp_even: -16384, exp_odd:  16384};
        vecs[3] = '{mode: 2'd1, per: 16'd0,  exp_even:  16384, exp_odd:  16384};
        vecs[4] = '{mode: 2'd0, per: 16'd3,  exp_even: -16384, exp_odd: -16384};
        vecs[5] = '{mode: 2'd2, per: 16'd13, exp_even: -16384, exp_odd:  16384};

        rst = 1'b1; en1 = 1'b0; rdy1 = 1'b0; clr1 = 1'b0; mode1 = 2'd0; per1 = 16'd8;
        en2 = 1'b0; rdy2 = 1'b0; clr2 = 1'b0; pdm2 = 2'b01; per2 = 16'd8;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_pdm_clk", int'(pclk1), 0);
        check("rst_m_valid", int'(valid1), 0);
        check("rst_m_data", int'(data1), 0);
        check("rst_m_channel", int'(ch1), 0);
        check("rst_m_last", int'(last1), 0);
        check("rst_fifo_level", int'(level1), 0);
        check("rst_overflow", int'(ovf1), 0);
        rst = 1'b0;

        // Clock: period 8 gives 4 high / 4 low; disable mid-high forces low
        en1 = 1'b1; rdy1 = 1'b1;
        t = 0;
        while (!pclk1 && t < 20) begin @(negedge clk); t++; end
        hi = 0;
        while (pclk1 && hi < 20) begin hi++; @(negedge clk); end
        lo = 0;
        while (!pclk1 && lo < 20) begin lo++; @(negedge clk); end
        check("clk_high_cycles", hi, 4);
        check("clk_low_cycles", lo, 4);
        @(negedge clk);
        check("clk_mid_high", int'(pclk1), 1);
        en1 = 1'b0;
        @(negedge clk);
        check("clk_disable", int'(pclk1), 0);

        // Table: full scale, negative full scale, phase separation, edge periods
        for (int i = 0; i < 6; i++) begin
            pulse_reset();
            mode1 = vecs[i].mode; per1 = vecs[i].per; rdy1 = 1'b1; en1 = 1'b1;
            push_frame1(vecs[i].exp_even, vecs[i].exp_odd);
            push_frame1(vecs[i].exp_even, vecs[i].exp_odd);
            wait_q1_empty($sformatf("vector%0d", i));
            en1 = 1'b0;
            repeat (4) @(negedge clk);
        end

        // Overflow: 8 frames stored, 9th dropped, then drain in order
        pulse_reset();
        mode1 = 2'd1; per1 = 16'd0; rdy1 = 1'b0; en1 = 1'b1;
        t = 0;
        while (!ovf1 && t < BUDGET) begin @(negedge clk); t++; end
        en1 = 1'b0;
        if (!ovf1) timeout_fail("overflow_wait");
        check("ovf_level", int'(level1), 16);
        check("ovf_valid", int'(valid1), 1);
`ifdef PDM_MIC_ARRAY_DROP_CNT_EN
        check("ovf_drop_count", int'(drop1), 1);
`endif
        repeat (3) @(negedge clk);
        check("stall_data", int'($signed(data1)), 16384);
        check("stall_channel", int'(ch1), 0);
        check("stall_level", int'(level1), 16);
        for (int f = 0; f < 8; f++) push_frame1(16384, 16384);
        rdy1 = 1'b1;
        wait_q1_empty("overflow_drain");
        repeat (2) @(negedge clk);
        check("drain_level", int'(level1), 0);
        check("drain_valid", int'(valid1), 0);
        check("ovf_retained", int'(ovf1), 1);
        clr1 = 1'b1;
        @(negedge clk);
        clr1 = 1'b0;
        check("ovf_cleared", int'(ovf1), 0);
`ifdef PDM_MIC_ARRAY_DROP_CNT_EN
        check("drop_count_cleared", int'(drop1), 0);
`endif

        // Reset with 5 entries queued and the comb mid-frame, then settle again
        pulse_reset();
        mode1 = 2'd1; per1 = 16'd0; rdy1 = 1'b0; en1 = 1'b1;
        t = 0;
        while (level1 != 5'd5 && t < BUDGET) begin @(negedge clk); t++; end
        check("pre_reset_level", int'(level1), 5);
        rst = 1'b1;
        @(negedge clk);
        check("reset_valid", int'(valid1), 0);
        check("reset_level", int'(level1), 0);
        rst = 1'b0; rdy1 = 1'b1;
        push_frame1(16384, 16384);
        push_frame1(16384, 16384);
        wait_q1_empty("post_reset_settle");
        en1 = 1'b0;

        // Two lines: channel order 0..3, ch2 written 3 cycles after decimation
        en2 = 1'b1; rdy2 = 1'b0;
        idx = 0; rise_idx = -100; prev = 1'b0; t = 0;
        while (level2 == 5'd0 && t < BUDGET) begin
            @(negedge clk);
            idx++; t++;
            if (pclk2 && !prev) rise_idx = idx;
            prev = pclk2;
        end
        check("order_first_level", int'(level2), 1);
        check("order_first_delay", idx - rise_idx, 1);
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("order_level_%0d", k), int'(level2), k);
        end
        for (int f = 0; f < 2; f++) begin
            q2.push_back('{data: 16'(16384),  ch: 2'd0, last: 1'b0});
            q2.push_back('{data: 16'(16384),  ch: 2'd1, last: 1'b0});
            q2.push_back('{data: 16'(-16384), ch: 2'd2, last: 1'b0});
            q2.push_back('{data: 16'(-16384), ch: 2'd3, last: 1'b1});
        end
        rdy2 = 1'b1;
        t = 0;
        while (q2.size() != 0 && t < BUDGET) begin @(negedge clk); t++; end
        if (q2.size() != 0) begin
            timeout_fail("order_drain");
            q2.delete();
        end
        en2 = 1'b0;
        repeat (4) @(negedge clk);
        check("order_no_overflow", int'(ovf2), 0);
`ifdef PDM_MIC_ARRAY_DROP_CNT_EN
        check("order_drop_count", int'(drop2), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
